// File: rtl/processador_pkg.sv
// Shared constants and types for the processor and its program loader.
// Instruction word layout: opcode in the high nibble, operando in the low nibble.
package processador_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int MEM_DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } loaderState_t;

    localparam int OPCODE_MSB   = 7;
    localparam int OPCODE_LSB   = 4;
    localparam int OPERANDO_MSB = 3;
    localparam int OPERANDO_LSB = 0;

endpackage

// File: rtl/carregador_programa_if.sv
// Loader bus: operator controls, the switch word, the processor fetch port and loader status.
// The slave modport is the loader side; the master modport is the board/processor side.
interface carregador_programa_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);

    logic              Start;
    logic              Finish;
    logic              Strobe;
    logic [DATA_W-1:0] DataIn;
    logic [ADDR_W-1:0] RdAddr;
    logic [DATA_W-1:0] RdData;
    logic              Run;
    logic              Loading;
    logic [ADDR_W:0]   WordCount;
    logic [DATA_W-1:0] Echo;

    modport slave (
        input  Start, Finish, Strobe, DataIn, RdAddr,
        output RdData, Run, Loading, WordCount, Echo
    );

    modport master (
        output Start, Finish, Strobe, DataIn, RdAddr,
        input  RdData, Run, Loading, WordCount, Echo
    );

endinterface

// File: rtl/memoria_ram.sv
// Program RAM: one write port and a registered read-first fetch port.
// With CARREGADOR_ECO_EN defined, a second registered read port drives the echo word.
module memoria_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
`ifdef CARREGADOR_ECO_EN
    ,
    input  logic [ADDR_W-1:0] echoAddr,
    input  logic              echoZero,
    output logic [DATA_W-1:0] echoData
`endif
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Contents survive reset; reads see the pre-write value in a same-address cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wrAddr] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdData <= '0;
        end else begin
            rdData <= mem[rdAddr];
        end
    end

`ifdef CARREGADOR_ECO_EN
    always_ff @(posedge clk) begin
        if (rst || echoZero) begin
            echoData <= '0;
        end else begin
            echoData <= mem[echoAddr];
        end
    end
`endif

endmodule

// File: rtl/carregador_programa.sv
// Program loader: synchronises the KEY strobe, writes one switch word per press and releases Run.
// Optional echo readback of the last written word is built when CARREGADOR_ECO_EN is defined.
module carregador_programa #(
    parameter int DATA_W      = processador_pkg::DATA_W,
    parameter int ADDR_W      = processador_pkg::ADDR_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    carregador_programa_if.slave bus
);

    import processador_pkg::*;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(2 ** ADDR_W);

    loaderState_t            state;
    logic [SYNC_STAGES-1:0]  strobeSync_p0;
    logic                    strobeEdge_p1;
    logic                    wrPulse;
    logic                    wrEn;
    logic [ADDR_W-1:0]       wrAddr;
    logic [ADDR_W:0]         wordCount;
    logic [ADDR_W:0]         wordCountNext;
    logic                    run;
    logic                    loading;

    // Stage p0: metastability chain on the raw push-button level
    always_ff @(posedge Clock) begin
        if (Reset) begin
            strobeSync_p0 <= '0;
            strobeEdge_p1 <= 1'b0;
        end else begin
            strobeSync_p0 <= {strobeSync_p0[SYNC_STAGES-2:0], bus.Strobe};
            // Stage p1: previous synchronised level for rising-edge detection
            strobeEdge_p1 <= strobeSync_p0[SYNC_STAGES-1];
        end
    end

    assign wrPulse       = strobeSync_p0[SYNC_STAGES-1] & ~strobeEdge_p1;
    assign wrEn          = (state == LOAD) && wrPulse && !bus.Start;
    assign wordCountNext = wordCount + 1'b1;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            wrAddr    <= '0;
            wordCount <= '0;
            run       <= 1'b0;
            loading   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state     <= LOAD;
                        wrAddr    <= '0;
                        wordCount <= '0;
                        loading   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.Start) begin
                        wrAddr    <= '0;
                        wordCount <= '0;
                    end else begin
                        if (wrPulse) begin
                            wrAddr    <= wrAddr + 1'b1;
                            wordCount <= wordCountNext;
                        end
                        // A write coinciding with Finish still lands before the exit.
                        if ((wrPulse && wordCountNext == FULL_COUNT) || bus.Finish) begin
                            state   <= DONE;
                            run     <= 1'b1;
                            loading <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (bus.Start) begin
                        state     <= LOAD;
                        wrAddr    <= '0;
                        wordCount <= '0;
                        run       <= 1'b0;
                        loading   <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    run     <= 1'b0;
                    loading <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Run       = run;
    assign bus.Loading   = loading;
    assign bus.WordCount = wordCount;

    memoria_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_memoria (
        .clk     (Clock),
        .rst     (Reset),
        .we      (wrEn),
        .wrAddr  (wrAddr),
        .wrData  (bus.DataIn),
        .rdAddr  (bus.RdAddr),
        .rdData  (bus.RdData)
`ifdef CARREGADOR_ECO_EN
        ,
        .echoAddr(wrAddr - 1'b1),
        .echoZero(wordCount == '0),
        .echoData(bus.Echo)
`endif
    );

`ifndef CARREGADOR_ECO_EN
    assign bus.Echo = '0;
`endif

endmodule
